// File: rtl/mem_burst_tester.sv
// Write/read-back burst traffic generator and checker for the DDR3 burst controller.
// Optional `MEM_BURST_TESTER_ERR_INJECT_EN adds err_inject to corrupt one written word.
module mem_burst_tester #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 24,
  parameter int BURST_LEN     = 128
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     init_calib_complete,
  input  logic                     test_en,
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
  input  logic                     err_inject,
`endif
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     rd_burst_req,
  output logic [9:0]               rd_burst_len,
  output logic [ADDR_BITS-1:0]     rd_burst_addr,
  input  logic                     rd_burst_data_valid,
  input  logic [MEM_DATA_BITS-1:0] rd_burst_data,
  input  logic                     rd_burst_finish,
  output logic                     error,
  output logic [15:0]              error_cnt,
  output logic [31:0]              burst_cnt
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, NEXT} state_t;

  localparam int          WORDS32 = MEM_DATA_BITS / 32;
  localparam logic [10:0] LEN11   = 11'(BURST_LEN);

  state_t                   state;
  logic [ADDR_BITS-1:0]     addr;
  logic [31:0]              seed;
  logic [10:0]              wr_cnt;
  logic [10:0]              rd_cnt;
  logic [MEM_DATA_BITS-1:0] wr_word;
  logic [MEM_DATA_BITS-1:0] rd_expect;
  logic                     rd_mismatch;
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
  logic                     inj_armed;
`endif

  function automatic logic [MEM_DATA_BITS-1:0] pattern(input logic [31:0] v);
    return {WORDS32{v}};
  endfunction

  assign wr_burst_len  = 10'(BURST_LEN);
  assign rd_burst_len  = 10'(BURST_LEN);
  assign wr_burst_addr = addr;
  assign rd_burst_addr = addr;

  always_comb begin
    wr_word = pattern(seed + 32'(wr_cnt));
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
    wr_word[0] = wr_word[0] ^ inj_armed;
`endif
    rd_expect   = pattern(seed + 32'(rd_cnt));
    rd_mismatch = (rd_burst_data != rd_expect);
  end

  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wr_burst_req  <= 1'b0;
      rd_burst_req  <= 1'b0;
      addr          <= '0;
      wr_burst_data <= '0;
      seed          <= '0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      error         <= 1'b0;
      error_cnt     <= '0;
      burst_cnt     <= '0;
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
      inj_armed     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (init_calib_complete && test_en) begin
            state        <= WRITE;
            wr_burst_req <= 1'b1;
            wr_cnt       <= '0;
          end
        end
        WRITE: begin
          // Data lands one cycle after the request, aligned with the controller's registered write enable.
          if (wr_burst_data_req) begin
            wr_burst_data <= wr_word;
            wr_cnt        <= wr_cnt + 11'd1;
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
            inj_armed     <= 1'b0;
`endif
          end
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            rd_burst_req <= 1'b1;
            rd_cnt       <= '0;
            state        <= READ;
          end
        end
        READ: begin
          if (rd_burst_data_valid) begin
            rd_cnt <= rd_cnt + 11'd1;
            if (rd_mismatch) begin
              error <= 1'b1;
              if (error_cnt != '1) error_cnt <= error_cnt + 16'd1;
            end
          end
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            state        <= NEXT;
          end
        end
        NEXT: begin
          if (rd_cnt != LEN11) begin
            error <= 1'b1;
            if (error_cnt != '1) error_cnt <= error_cnt + 16'd1;
          end
          burst_cnt <= burst_cnt + 32'd1;
          addr      <= addr + ADDR_BITS'(BURST_LEN);
          seed      <= seed + 32'(BURST_LEN);
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
      // A new pulse re-arms even when a word is being written this cycle.
      if (err_inject) inj_armed <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_mem_burst_tester.sv
// Directed bench for mem_burst_tester: table of write/read pairs against a controller model,
// plus hand sequences for idle stop, reset during read and address wrap on a small instance.
module tb_mem_burst_tester;

  localparam int BL = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_calib_complete;
  logic        test_en;
  logic        wr_burst_req;
  logic [9:0]  wr_burst_len;
  logic [23:0] wr_burst_addr;
  logic        wr_burst_data_req;
  logic [63:0] wr_burst_data;
  logic        wr_burst_finish;
  logic        rd_burst_req;
  logic [9:0]  rd_burst_len;
  logic [23:0] rd_burst_addr;
  logic        rd_burst_data_valid;
  logic [63:0] rd_burst_data;
  logic        rd_burst_finish;
  logic        error;
  logic [15:0] error_cnt;
  logic [31:0] burst_cnt;

  logic        en2;
  logic        wr_req2, wr_dreq2, wr_fin2, rd_req2, rd_val2, rd_fin2, error2;
  logic [9:0]  wr_len2, rd_len2, wr_addr2, rd_addr2;
  logic [63:0] wr_data2, rd_data2;
  logic [15:0] err_cnt2;
  logic [31:0] bc2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_burst_tester #(.MEM_DATA_BITS(64), .ADDR_BITS(24), .BURST_LEN(BL)) dut (
    .mem_clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .test_en(test_en),
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len), .wr_burst_addr(wr_burst_addr),
    .wr_burst_data_req(wr_burst_data_req), .wr_burst_data(wr_burst_data),
    .wr_burst_finish(wr_burst_finish), .rd_burst_req(rd_burst_req), .rd_burst_len(rd_burst_len),
    .rd_burst_addr(rd_burst_addr), .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data(rd_burst_data), .rd_burst_finish(rd_burst_finish),
    .error(error), .error_cnt(error_cnt), .burst_cnt(burst_cnt)
  );

  mem_burst_tester #(.MEM_DATA_BITS(64), .ADDR_BITS(10), .BURST_LEN(256)) dut2 (
    .mem_clk(clk), .rst(rst), .init_calib_complete(init_calib_complete), .test_en(en2),
`ifdef MEM_BURST_TESTER_ERR_INJECT_EN
    .err_inject(1'b0),
`endif
    .wr_burst_req(wr_req2), .wr_burst_len(wr_len2), .wr_burst_addr(wr_addr2),
    .wr_burst_data_req(wr_dreq2), .wr_burst_data(wr_data2), .wr_burst_finish(wr_fin2),
    .rd_burst_req(rd_req2), .rd_burst_len(rd_len2), .rd_burst_addr(rd_addr2),
    .rd_burst_data_valid(rd_val2), .rd_burst_data(rd_data2), .rd_burst_finish(rd_fin2),
    .error(error2), .error_cnt(err_cnt2), .burst_cnt(bc2)
  );

  // Ideal memory/controller for the small instance; logs each pair's address and first word.
  logic [63:0] mem2 [0:255];
  logic [9:0]  addr2_log [0:7];
  logic [31:0] v2_log [0:7];
  int ph2 = 0, iss2 = 0, rcnt2 = 0, pair2 = 0;
  bit prev2 = 0;

  always @(negedge clk) begin
    if (rst) begin
      ph2 = 0; pair2 = 0; prev2 = 0;
      wr_dreq2 = 0; wr_fin2 = 0; rd_val2 = 0; rd_fin2 = 0; rd_data2 = '0;
    end else begin
      case (ph2)
        0: if (wr_req2) begin
             if (pair2 < 8) addr2_log[pair2] = wr_addr2;
             iss2 = 0; prev2 = 0; ph2 = 1;
           end
        1: begin
             if (prev2) begin
               mem2[iss2-1] = wr_data2;
               if (iss2 == 1 && pair2 < 8) v2_log[pair2] = wr_data2[31:0];
             end
             if (iss2 < 256) begin wr_dreq2 = 1; iss2++; prev2 = 1; end
             else begin wr_dreq2 = 0; prev2 = 0; wr_fin2 = 1; ph2 = 2; end
           end
        2: begin wr_fin2 = 0; ph2 = 3; end
        3: if (rd_req2) begin rcnt2 = 0; ph2 = 4; end
        4: if (rcnt2 < 256) begin rd_val2 = 1; rd_data2 = mem2[rcnt2]; rcnt2++; end
           else begin rd_val2 = 0; rd_fin2 = 1; ph2 = 5; end
        default: begin rd_fin2 = 0; pair2++; ph2 = 0; end
      endcase
    end
  end

  typedef struct {
    int          nvalid;     // read words returned before finish
    int          corrupt;    // read word index with bit 63 flipped, -1 none
    int          gaps;       // random wr_burst_data_req stalls
    int          mode;       // 0 plain, 1 drop test_en in write, 2 drop calib in write, 3 reset in read
    logic [23:0] exp_addr;
    logic [31:0] exp_seed;
    logic        exp_error;
    logic [15:0] exp_err_cnt;
    logic [31:0] exp_burst_cnt;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] x);
    return {x, x};
  endfunction

  task automatic run_pair(input vec_t v);
    int t;
    int issued;
    bit prev, seq, hold;
    logic [63:0] w;
    t = 0;
    while (!wr_burst_req && t < 1000) begin @(negedge clk); t++; end
    chk("wr_req_seen", wr_burst_req, 1);
    chk("wr_addr", wr_burst_addr, v.exp_addr);
    issued = 0; prev = 0; seq = 1; hold = 1;
    while (1) begin
      if (!wr_burst_req || rd_burst_req || wr_burst_addr !== v.exp_addr) hold = 0;
      if (prev) begin
        if (wr_burst_data !== pat(v.exp_seed + 32'(issued - 1))) seq = 0;
        prev = 0;
      end
      if (issued == BL) break;
      if (v.mode == 1 && issued == 10) test_en = 0;
      if (v.mode == 2 && issued == 20) init_calib_complete = 0;
      if (v.gaps != 0 && $urandom_range(0, 2) == 0) wr_burst_data_req = 0;
      else begin wr_burst_data_req = 1; issued++; prev = 1; end
      @(negedge clk);
    end
    wr_burst_data_req = 0;
    init_calib_complete = 1;
    chk("wr_seq", seq, 1);
    chk("wr_hold", hold, 1);
    wr_burst_finish = 1;
    @(negedge clk);
    wr_burst_finish = 0;
    t = 0;
    while (!rd_burst_req && t < 1000) begin @(negedge clk); t++; end
    chk("rd_req_seen", rd_burst_req, 1);
    chk("wr_req_dropped", wr_burst_req, 0);
    chk("rd_addr", rd_burst_addr, v.exp_addr);
    for (int i = 0; i < v.nvalid; i++) begin
      if (v.mode == 3 && i == 10) begin
        rd_burst_data_valid = 0;
        rst = 1;
        #1;
        chk("rst_rd_req", rd_burst_req, 0);
        chk("rst_wr_req", wr_burst_req, 0);
        chk("rst_addr", {wr_burst_addr, rd_burst_addr}, 0);
        chk("rst_wr_data", wr_burst_data, 0);
        chk("rst_error", error, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        test_en = 0;
        @(negedge clk);
        rst = 0;
        return;
      end
      if (!rd_burst_req || wr_burst_req || rd_burst_addr !== v.exp_addr) hold = 0;
      w = pat(v.exp_seed + 32'(i));
      if (i == v.corrupt) w[63] = ~w[63];
      rd_burst_data_valid = 1;
      rd_burst_data = w;
      @(negedge clk);
    end
    rd_burst_data_valid = 0;
    rd_burst_finish = 1;
    @(negedge clk);
    rd_burst_finish = 0;
    @(negedge clk);
    chk("rd_hold", hold, 1);
    chk("rd_req_done", rd_burst_req, 0);
    chk("error", error, v.exp_error);
    chk("error_cnt", error_cnt, v.exp_err_cnt);
    chk("burst_cnt", burst_cnt, v.exp_burst_cnt);
  endtask

  vec_t tbl [7];
  vec_t hv;

  initial begin
    tbl[0] = '{128, -1, 0, 0, 24'd0,   32'd0,   1'b0, 16'd0, 32'd1};
    tbl[1] = '{128, -1, 0, 0, 24'd128, 32'd128, 1'b0, 16'd0, 32'd2};
    tbl[2] = '{128,  5, 0, 0, 24'd256, 32'd256, 1'b1, 16'd1, 32'd3};
    tbl[3] = '{128, -1, 1, 2, 24'd384, 32'd384, 1'b1, 16'd1, 32'd4};
    tbl[4] = '{127, -1, 0, 0, 24'd512, 32'd512, 1'b1, 16'd2, 32'd5};
    tbl[5] = '{129, -1, 0, 0, 24'd640, 32'd640, 1'b1, 16'd3, 32'd6};
    tbl[6] = '{127,  3, 0, 0, 24'd768, 32'd768, 1'b1, 16'd5, 32'd7};

    rst = 1; init_calib_complete = 0; test_en = 0; en2 = 0;
    wr_burst_data_req = 0; wr_burst_finish = 0;
    rd_burst_data_valid = 0; rd_burst_data = '0; rd_burst_finish = 0;
    repeat (2) @(negedge clk);
    chk("reset_wr_req", wr_burst_req, 0);
    chk("reset_rd_req", rd_burst_req, 0);
    chk("reset_addr", {wr_burst_addr, rd_burst_addr}, 0);
    chk("reset_wr_data", wr_burst_data, 0);
    chk("reset_error", {error, error_cnt}, 0);
    chk("reset_burst_cnt", burst_cnt, 0);
    chk("burst_len", {wr_burst_len, rd_burst_len}, {10'd128, 10'd128});
    chk("burst_len2", wr_len2, 256);

    rst = 0; test_en = 1;
    repeat (10) @(negedge clk);
    chk("no_req_uncal", wr_burst_req, 0);

    // Address wrap on the 10-bit, 256-word instance.
    test_en = 0; init_calib_complete = 1; en2 = 1;
    for (int t = 0; t < 6000 && bc2 != 32'd5; t++) @(negedge clk);
    en2 = 0;
    repeat (4) @(negedge clk);
    chk("wrap_burst_cnt", bc2, 5);
    chk("wrap_error", error2, 0);
    chk("wrap_idle", wr_req2, 0);
    for (int p = 0; p < 5; p++) begin
      chk("wrap_addr", addr2_log[p], (p * 256) % 1024);
      chk("wrap_seed", v2_log[p], p * 256);
    end

    test_en = 1;
    for (int i = 0; i < 7; i++) run_pair(tbl[i]);

    // Stop after the current pair, then resume at the next address.
    @(negedge clk); rst = 1; @(negedge clk); rst = 0;
    hv = '{128, -1, 0, 1, 24'd0, 32'd0, 1'b0, 16'd0, 32'd1};
    run_pair(hv);
    repeat (20) @(negedge clk);
    chk("stopped_idle", wr_burst_req, 0);
    chk("stopped_cnt", burst_cnt, 1);
    test_en = 1;
    hv = '{128, -1, 0, 0, 24'd128, 32'd128, 1'b0, 16'd0, 32'd2};
    run_pair(hv);

    hv = '{128, -1, 0, 3, 24'd256, 32'd256, 1'b0, 16'd0, 32'd0};
    run_pair(hv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_tester.md
Name: mem_burst_tester

Overview:
- Traffic generator and checker sitting directly upstream of the DDR3 burst controller, driving its rd/wr burst request interface.
- Repeatedly writes one burst of a deterministic pattern, reads the same burst back, and compares every returned word on the fly.
- Advances through the address space burst by burst and reports sticky error status, an error count and a completed-burst count for LEDs/ILA.

Parameters:
MEM_DATA_BITS, 64, width of burst data words; must be a multiple of 32
ADDR_BITS, 24, burst address width (word units, matches controller)
BURST_LEN, 128, words per burst, 1..1023; power of two dividing 2^ADDR_BITS

Ports:
mem_clk  in  1  controller interface clock
rst  in  1  asynchronous active-high reset
init_calib_complete  in  1  DDR calibration done; no request issued while low
test_en  in  1  level; 1 = run continuously, 0 = stop after current write/read pair
wr_burst_req  out  1  write burst request, held until wr_burst_finish
wr_burst_len  out  10  constant BURST_LEN
wr_burst_addr  out  ADDR_BITS  write burst start address
wr_burst_data_req  in  1  controller consumes one word this cycle
wr_burst_data  out  MEM_DATA_BITS  write data, registered
wr_burst_finish  in  1  write burst complete pulse
rd_burst_req  out  1  read burst request, held until rd_burst_finish
rd_burst_len  out  10  constant BURST_LEN
rd_burst_addr  out  ADDR_BITS  read burst start address
rd_burst_data_valid  in  1  read data valid
rd_burst_data  in  MEM_DATA_BITS  read data
rd_burst_finish  in  1  read burst complete pulse
error  out  1  sticky: any mismatch or length error since reset
error_cnt  out  16  mismatching words + length errors, saturates at 16'hFFFF
burst_cnt  out  32  completed write/read pairs, wraps

Behaviour:
- Reset (async, rst=1): state IDLE; wr/rd_burst_req=0; addresses=0; wr_burst_data=0; seed=0; word counters=0; error=0; error_cnt=0; burst_cnt=0.
- Pattern: word k of a burst = V replicated MEM_DATA_BITS/32 times, V = seed + k (32-bit, wraps). Seed starts at 0, advances by BURST_LEN per pair.
- States:
  IDLE: if init_calib_complete & test_en -> WRITE; assert wr_burst_req next cycle; wr_cnt=0.
  WRITE: each cycle wr_burst_data_req=1: wr_burst_data <= pattern(wr_cnt), wr_cnt++. Data therefore valid the cycle after the request, matching the controller's registered write-enable. On wr_burst_finish: drop wr_burst_req -> READ; assert rd_burst_req; rd_cnt=0.
  READ: each rd_burst_data_valid: compare rd_burst_data with pattern(rd_cnt), rd_cnt++. Mismatch: error=1, error_cnt++ (saturating). On rd_burst_finish: drop rd_burst_req -> NEXT.
  NEXT (1 cycle): if rd_cnt != BURST_LEN, count one length error. burst_cnt++; address += BURST_LEN (mod 2^ADDR_BITS); seed += BURST_LEN -> IDLE.
- wr_burst_addr and rd_burst_addr are equal and stable while the corresponding request is high.
- Requests are never both high; requests are held high until the matching finish.
- Extra rd_burst_data_valid beyond BURST_LEN words: compared against pattern(rd_cnt) with rd_cnt continuing (counter width 11 bits); length error flagged in NEXT.
- Mismatch and length error in the same burst each count separately.
- test_en deasserted mid-pair: the pair completes, then the block stays in IDLE. Reasserting resumes at the next address/seed.
- init_calib_complete dropping mid-burst: no effect on the state machine (the controller stalls).
- Address wrap: after the burst at 2^ADDR_BITS - BURST_LEN, the next address is 0; seed continues.
- Reset mid-operation: immediate return to reset values, no finish required.

Optional Feature:
- MEM_BURST_TESTER_ERR_INJECT_EN defined: adds input port err_inject (1 bit). A pulse arms injection; bit 0 of the next written word is inverted, then injection disarms. The checker still expects the clean pattern, so exactly one mismatch results.
- Not defined: the port is absent and written data is always the clean pattern.

Test Plan:
- Ideal controller model, BURST_LEN=128, test_en=1: first write at addr 0 with words V=0..127, read at addr 0, next pair at addr 128 with V=128..255; error=0, burst_cnt=2 after two pairs.
- Model corrupts read word 5 of the first burst (bit 63 flipped): error=1, error_cnt=1; later clean bursts leave error_cnt at 1.
- Model returns only 127 valid words, then rd_burst_finish: error_cnt=1 (length error), burst_cnt still increments.
- Random wr_burst_data_req gaps (app_wdf_rdy stalls): written sequence still exactly 0..127 with no duplicates or skips; readback is clean.
- ADDR_BITS=10, BURST_LEN=256: pairs at addr 0, 256, 512, 768, then 0; seed keeps increasing (the fifth pair starts at V=1024).
- test_en dropped during WRITE: the read still completes, burst_cnt=1, block idles. rst pulsed during READ: all outputs return to reset values within the same cycle.
